// File: rtl/usb_in_pingpong.sv
// Double-buffered IN endpoint buffer: the producer fills one page while the
// protocol layer drains the other; pages are handed over via a commit handshake.
module usb_in_pingpong #(
   parameter int ADDR_W  = 9,
   parameter int LEN_W   = 11,
   parameter int HOLDOFF = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] buf_in_addr,
   input  logic [31:0]       buf_in_data,
   input  logic              buf_in_wren,
   output logic              buf_in_request,
   output logic              buf_in_ready,
   input  logic              buf_in_commit,
   input  logic [LEN_W-1:0]  buf_in_commit_len,
   output logic              buf_in_commit_ack,
   input  logic              ep_in_req,
   output logic              ep_has_data,
   output logic [LEN_W-1:0]  ep_len,
   input  logic [ADDR_W-1:0] ep_rd_addr,
   output logic [31:0]       ep_rd_q,
   input  logic              ep_done,
   output logic [15:0]       drop_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {C_IDLE, C_ACK, C_HOLD} cstate_t;

   cstate_t          cs, ns;
   logic [31:0]      mem [0:2*DEPTH-1];
   logic [1:0]       full;
   logic             wp, rp;
   logic [LEN_W-1:0] len [0:1];
   logic [CNT_W-1:0] hold_cnt;
   logic             accept, hold_load, rel;

   assign rel    = ep_done && full[rp];
   assign ep_len = len[rp];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cs <= C_IDLE;
      else       cs <= ns;
   end

   always_comb begin
      ns = cs;
      case (cs)
         C_IDLE:  if (accept) ns = C_ACK;
         C_ACK:   if (!buf_in_commit) ns = C_HOLD;
         C_HOLD:  if (hold_cnt == '0) ns = C_IDLE;
         default: ns = C_IDLE;
      endcase
   end

   // A commit against a FULL write page is simply not accepted; it retries
   // every cycle in C_IDLE until ep_done frees that page.
   always_comb begin
      accept    = 1'b0;
      hold_load = 1'b0;
      case (cs)
         C_IDLE:  accept    = buf_in_commit && !full[wp];
         C_ACK:   hold_load = !buf_in_commit;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (buf_in_wren && !full[wp]) mem[{wp, buf_in_addr}] <= buf_in_data;
   end

   // accept touches page wp (FREE) and rel touches page rp (FULL), so the
   // two full[] updates below never land on the same page.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full              <= '0;
         wp                <= 1'b0;
         rp                <= 1'b0;
         len[0]            <= '0;
         len[1]            <= '0;
         hold_cnt          <= '0;
         buf_in_commit_ack <= 1'b0;
         buf_in_request    <= 1'b0;
         buf_in_ready      <= 1'b0;
         ep_has_data       <= 1'b0;
         ep_rd_q           <= '0;
         drop_cnt          <= '0;
      end else begin
         if (accept) begin
            full[wp] <= 1'b1;
            len[wp]  <= buf_in_commit_len;
            wp       <= ~wp;
         end
         if (rel) begin
            full[rp] <= 1'b0;
            rp       <= ~rp;
         end
         if (hold_load)
            hold_cnt <= CNT_W'(HOLDOFF);
         else if (cs == C_HOLD && hold_cnt != '0)
            hold_cnt <= hold_cnt - CNT_W'(1);
         if (buf_in_wren && full[wp] && drop_cnt != '1)
            drop_cnt <= drop_cnt + 16'd1;
         buf_in_commit_ack <= (ns == C_ACK);
         buf_in_request    <= ep_in_req && (cs == C_IDLE);
         buf_in_ready      <= !full[wp];
         ep_has_data       <= full[rp];
         ep_rd_q           <= mem[{rp, ep_rd_addr}];
      end
   end

endmodule

// File: doc/usb_in_pingpong.md
Name: usb_in_pingpong

Overview:
Double-buffered (ping-pong) IN endpoint buffer that sits directly downstream of the LFSR/test data source. It accepts 32-bit words plus a four-phase commit handshake on the producer-side buf_in_* interface and presents full pages to the USB protocol layer for transmission. Pages are released back to the producer when the protocol layer reports that the host has acknowledged them. Everything runs on a single clock.

Parameters:
ADDR_W, 9, word address width; page depth is 2**ADDR_W 32-bit words.
LEN_W, 11, byte-length field width for commit_len and ep_len.
HOLDOFF, 4, minimum number of cycles buf_in_request stays low after buf_in_commit_ack falls.

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high reset.
buf_in_addr  in  ADDR_W  producer write word address.
buf_in_data  in  32  producer write data.
buf_in_wren  in  1  producer write strobe, one word per cycle.
buf_in_request  out  1  host demand for data, gated as described under Behaviour.
buf_in_ready  out  1  the write page is FREE.
buf_in_commit  in  1  level; held by the producer until it sees ack.
buf_in_commit_len  in  LEN_W  byte length of the committed page.
buf_in_commit_ack  out  1  commit accepted.
ep_in_req  in  1  level from the protocol layer: host is polling the IN endpoint.
ep_has_data  out  1  the read page is FULL.
ep_len  out  LEN_W  latched byte length of the read page.
ep_rd_addr  in  ADDR_W  read word address into the read page.
ep_rd_q  out  32  read data; registered, 1-cycle latency.
ep_done  in  1  1-cycle pulse: read page transmitted and acked by the host; release it.
drop_cnt  out  16  saturating count of writes rejected.

Behaviour:
- Storage: two pages P0/P1, each 2**ADDR_W x 32, each with a state FREE or FULL and a latched length len[p]. The write page index is wp; the read page index is rp.
- Reset values: all pages FREE, wp=rp=0, len[]=0, all outputs 0, commit FSM in C_IDLE, holdoff counter 0. Reset asserted mid-handshake aborts the transfer immediately; page contents are don't-care after reset.
- Write path: when buf_in_wren=1 and page wp is FREE, mem[wp][buf_in_addr] <= buf_in_data. When buf_in_wren=1 and page wp is not FREE, the write is discarded and drop_cnt increments; drop_cnt saturates at 0xFFFF.
- buf_in_ready is registered and equals (state[wp]==FREE).
- Commit FSM:
  - C_IDLE: if buf_in_commit=1 and state[wp]==FREE, then len[wp]<=buf_in_commit_len, state[wp]<=FULL, wp toggles, buf_in_commit_ack<=1, and the FSM goes to C_ACK. If state[wp] is FULL, the FSM stays in C_IDLE with no ack (the commit is deferred until the page is freed).
  - C_ACK: hold ack=1 while buf_in_commit=1. When buf_in_commit=0: ack<=0, load the holdoff counter with HOLDOFF, go to C_HOLD.
  - C_HOLD: decrement the counter each cycle; at 0, go to C_IDLE.
  - A commit is accepted at most once per handshake. Commit rising again during C_HOLD is not serviced until C_IDLE.
- buf_in_request is registered and equals ep_in_req AND (FSM==C_IDLE). This guarantees the producer sees request low for at least HOLDOFF+1 cycles after every commit, even while ep_in_req stays high continuously.
- Read path:
  - ep_rd_q <= mem[rp][ep_rd_addr] every cycle.
  - ep_has_data is registered: (state[rp]==FULL).
  - ep_len = len[rp].
- Release: ep_done=1 while state[rp]==FULL sets state[rp]<=FREE and toggles rp. ep_done while rp is FREE is ignored.
- Simultaneous events:
  - ep_done and a commit acceptance in the same cycle both take effect.
  - A commit blocked because both pages are FULL is accepted on the first cycle after ep_done frees the write page (wp==rp in that case).
- Ordering: pages are delivered strictly in commit order; rp never overtakes wp.
- Zero-length commit (len=0) is legal: the page becomes FULL and ep_len reports 0.

Test Plan:
- Reset, ep_in_req=1, producer writes 256 words of 0x00000000..0x000000FF to P0 and commits len=1024 -> ack rises, request low for ≥5 cycles, ep_has_data=1, ep_len=1024, and reading addr 5 returns 0x00000005 one cycle later.
- Commit two pages without any ep_done -> buf_in_ready=0. A third wren increments drop_cnt to 1. A third commit gets no ack until an ep_done pulse, after which ack asserts and ep_len reports the second page's length.
- ep_done pulse with no FULL page -> no state change; ep_has_data stays 0 and rp stays 0.
- ep_done and commit acceptance in the same cycle with P0 FULL and P1 being committed -> afterwards P0 is FREE, P1 is FULL, rp=1, wp=0.
- Assert reset during C_ACK -> ack=0, both pages FREE, drop_cnt=0 asynchronously, and the next handshake completes normally.
- Drive 70000 rejected writes -> drop_cnt holds 0xFFFF.
